// File: rtl/threshold_alarm_monitor_pkg.sv
// rtl/threshold_alarm_monitor_pkg.sv - shared state encoding and default sizing for the alarm monitor
package threshold_alarm_monitor_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_ARMING    = 2'd1,
    ST_ALARM     = 2'd2,
    ST_DISARMING = 2'd3
  } alarm_state_e;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_PERSIST = 3;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_EVT_W   = 8;

  // The alarm stays asserted while a disarm run is still being counted.
  function automatic logic state_is_alarm(input alarm_state_e st);
    return (st == ST_ALARM) || (st == ST_DISARMING);
  endfunction

endpackage

// File: rtl/threshold_alarm_monitor_if.sv
// rtl/threshold_alarm_monitor_if.sv - sample/threshold inputs and alarm/peak/event outputs
interface threshold_alarm_monitor_if #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] hi_thr;
  logic [WIDTH-1:0] lo_thr;
  logic             clr_peak;
  logic             alarm;
  logic             alarm_set;
  logic             alarm_clr;
  logic [WIDTH-1:0] peak;
  logic [EVT_W-1:0] event_count;
  logic             config_err;

  modport master (
    output sample_valid, sample, hi_thr, lo_thr, clr_peak,
    input  alarm, alarm_set, alarm_clr, peak, event_count, config_err
  );

  modport slave (
    input  sample_valid, sample, hi_thr, lo_thr, clr_peak,
    output alarm, alarm_set, alarm_clr, peak, event_count, config_err
  );
endinterface

// File: rtl/threshold_alarm_monitor_mag_cmp.sv
// rtl/threshold_alarm_monitor_mag_cmp.sv - unsigned magnitude comparator
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o,
  output logic             lt_o,
  output logic             eq_o
);
  assign gt_o = a_i > b_i;
  assign lt_o = a_i < b_i;
  assign eq_o = a_i == b_i;
endmodule

// File: rtl/threshold_alarm_monitor.sv
// rtl/threshold_alarm_monitor.sv - two-stage threshold alarm with persistence, hysteresis, peak and event count
module threshold_alarm_monitor
  import threshold_alarm_monitor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PERSIST = DEF_PERSIST,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int EVT_W   = DEF_EVT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  threshold_alarm_monitor_if.slave  mon_if
);

  logic             hi_gt, lo_lt;
  logic             hi_lt_unused, hi_eq_unused, lo_gt_unused, lo_eq_unused;
  logic             cfg_err;

  logic             s1_v_q, s1_gt_q, s1_lt_q;
  logic [WIDTH-1:0] s1_d_q;

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d, run_inc;
  logic             alarm_q, alarm_set_q, alarm_clr_q;
  logic [WIDTH-1:0] peak_q, peak_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic             alarm_now;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_hi (
    .a_i(mon_if.sample), .b_i(mon_if.hi_thr),
    .gt_o(hi_gt), .lt_o(hi_lt_unused), .eq_o(hi_eq_unused)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_lo (
    .a_i(mon_if.sample), .b_i(mon_if.lo_thr),
    .gt_o(lo_gt_unused), .lt_o(lo_lt), .eq_o(lo_eq_unused)
  );

  assign cfg_err = mon_if.lo_thr > mon_if.hi_thr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v_q  <= 1'b0;
      s1_gt_q <= 1'b0;
      s1_lt_q <= 1'b0;
      s1_d_q  <= '0;
    end else begin
      s1_v_q  <= mon_if.sample_valid;
      s1_gt_q <= hi_gt;
      s1_lt_q <= lo_lt;
      s1_d_q  <= mon_if.sample;
    end
  end

  assign run_inc   = run_q + 1'b1;
  assign alarm_now = state_is_alarm(state_q);

  // Idle cycles and a bad threshold configuration both leave the run untouched.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (s1_v_q && !cfg_err) begin
      case (state_q)
        ST_NORMAL: begin
          if (s1_gt_q) begin
            if (PERSIST == 1) begin
              state_d = ST_ALARM;
              run_d   = '0;
            end else begin
              state_d = ST_ARMING;
              run_d   = CNT_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        ST_ARMING: begin
          if (!s1_gt_q) begin
            state_d = ST_NORMAL;
            run_d   = '0;
          end else if (run_inc == CNT_W'(PERSIST)) begin
            state_d = ST_ALARM;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        ST_ALARM: begin
          if (s1_lt_q) begin
            if (PERSIST == 1) begin
              state_d = ST_NORMAL;
              run_d   = '0;
            end else begin
              state_d = ST_DISARMING;
              run_d   = CNT_W'(1);
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          if (!s1_lt_q) begin
            state_d = ST_ALARM;
            run_d   = '0;
          end else if (run_inc == CNT_W'(PERSIST)) begin
            state_d = ST_NORMAL;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
      endcase
    end
  end

  always_comb begin
    peak_d = peak_q;
    if (mon_if.clr_peak) begin
      peak_d = s1_v_q ? s1_d_q : '0;
    end else if (s1_v_q && (s1_d_q > peak_q)) begin
      peak_d = s1_d_q;
    end
    evt_d = evt_q;
    if (alarm_now && !alarm_q && (evt_q != {EVT_W{1'b1}})) begin
      evt_d = evt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_NORMAL;
      run_q       <= '0;
      alarm_q     <= 1'b0;
      alarm_set_q <= 1'b0;
      alarm_clr_q <= 1'b0;
      peak_q      <= '0;
      evt_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      alarm_q     <= alarm_now;
      alarm_set_q <= alarm_now && !alarm_q;
      alarm_clr_q <= !alarm_now && alarm_q;
      peak_q      <= peak_d;
      evt_q       <= evt_d;
    end
  end

  assign mon_if.alarm       = alarm_q;
  assign mon_if.alarm_set   = alarm_set_q;
  assign mon_if.alarm_clr   = alarm_clr_q;
  assign mon_if.peak        = peak_q;
  assign mon_if.event_count = evt_q;
  assign mon_if.config_err  = cfg_err;

endmodule

// File: tb/tb_threshold_alarm_monitor.sv
// tb/tb_threshold_alarm_monitor.sv - vector table, corner sequences and randomized model check
module tb_threshold_alarm_monitor;

  localparam int P = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  threshold_alarm_monitor_if #(.WIDTH(4), .EVT_W(8)) ifc ();

  threshold_alarm_monitor #(.WIDTH(4), .PERSIST(P), .CNT_W(4), .EVT_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mon_if(ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference: alarm flips after P consecutive qualifying samples, outputs trail by a register.
  bit m_s1v, m_s1gt, m_s1lt;
  int m_s1d;
  bit m_level;
  int m_streak;
  bit m_alarm, m_set, m_clr;
  int m_peak, m_evt;

  typedef struct {
    bit do_rst;
    bit v;
    int s;
    bit ea, es, ec;
    int ep, ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit v, int s, bit ea, bit es, bit ec, int ep, int ee);
    vec_t t;
    t.do_rst = r; t.v = v; t.s = s; t.ea = ea; t.es = es; t.ec = ec; t.ep = ep; t.ee = ee;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1v = 0; m_s1gt = 0; m_s1lt = 0; m_s1d = 0;
    m_level = 0; m_streak = 0;
    m_alarm = 0; m_set = 0; m_clr = 0; m_peak = 0; m_evt = 0;
  endtask

  task automatic model_step();
    bit qual;
    bit n_set;
    n_set   = m_level && !m_alarm;
    m_clr   = !m_level && m_alarm;
    m_set   = n_set;
    m_alarm = m_level;
    if (n_set && m_evt < 255) m_evt++;
    if (m_s1v && !(ifc.lo_thr > ifc.hi_thr)) begin
      qual = m_level ? m_s1lt : m_s1gt;
      if (qual) begin
        m_streak++;
        if (m_streak == P) begin
          m_level  = !m_level;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
    if (ifc.clr_peak) m_peak = m_s1v ? m_s1d : 0;
    else if (m_s1v && m_s1d > m_peak) m_peak = m_s1d;
    m_s1v  = ifc.sample_valid;
    m_s1d  = int'(ifc.sample);
    m_s1gt = ifc.sample > ifc.hi_thr;
    m_s1lt = ifc.sample < ifc.lo_thr;
  endtask

  task automatic tick(input bit v, input int s, input bit c);
    ifc.sample_valid = v;
    ifc.sample       = 4'(s);
    ifc.clr_peak     = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    ifc.sample_valid = 0; ifc.sample = 0; ifc.clr_peak = 0;
    rst = 1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " alarm"},     int'(ifc.alarm),       int'(m_alarm));
    chk({tag, " alarm_set"}, int'(ifc.alarm_set),   int'(m_set));
    chk({tag, " alarm_clr"}, int'(ifc.alarm_clr),   int'(m_clr));
    chk({tag, " peak"},      int'(ifc.peak),        m_peak);
    chk({tag, " evt"},       int'(ifc.event_count), m_evt);
    chk({tag, " cfg_err"},   int'(ifc.config_err),  int'(ifc.lo_thr > ifc.hi_thr));
  endtask

  initial begin
    ifc.sample_valid = 0; ifc.sample = 0; ifc.clr_peak = 0;
    ifc.hi_thr = 4'd10; ifc.lo_thr = 4'd5;
    model_reset();

    // arm 11,12,13 then disarm 4,3,7,2,1,0
    tbl.push_back(mk(1,0,0,  0,0,0, 0,0));
    tbl.push_back(mk(0,1,11, 0,0,0, 0,0));
    tbl.push_back(mk(0,1,12, 0,0,0,11,0));
    tbl.push_back(mk(0,1,13, 0,0,0,12,0));
    tbl.push_back(mk(0,0,0,  0,0,0,13,0));
    tbl.push_back(mk(0,0,0,  1,1,0,13,1));
    tbl.push_back(mk(0,0,0,  1,0,0,13,1));
    tbl.push_back(mk(0,1,4,  1,0,0,13,1));
    tbl.push_back(mk(0,1,3,  1,0,0,13,1));
    tbl.push_back(mk(0,1,7,  1,0,0,13,1));
    tbl.push_back(mk(0,1,2,  1,0,0,13,1));
    tbl.push_back(mk(0,1,1,  1,0,0,13,1));
    tbl.push_back(mk(0,1,0,  1,0,0,13,1));
    tbl.push_back(mk(0,0,0,  1,0,0,13,1));
    tbl.push_back(mk(0,0,0,  0,0,1,13,1));
    tbl.push_back(mk(0,0,0,  0,0,0,13,1));
    // idle gaps keep the run alive
    tbl.push_back(mk(1,0,0,  0,0,0, 0,0));
    tbl.push_back(mk(0,1,11, 0,0,0, 0,0));
    tbl.push_back(mk(0,0,0,  0,0,0,11,0));
    tbl.push_back(mk(0,0,0,  0,0,0,11,0));
    tbl.push_back(mk(0,1,12, 0,0,0,11,0));
    tbl.push_back(mk(0,0,0,  0,0,0,12,0));
    tbl.push_back(mk(0,1,13, 0,0,0,12,0));
    tbl.push_back(mk(0,0,0,  0,0,0,13,0));
    tbl.push_back(mk(0,0,0,  1,1,0,13,1));
    // sample equal to hi_thr breaks the run
    tbl.push_back(mk(1,0,0,  0,0,0, 0,0));
    tbl.push_back(mk(0,1,11, 0,0,0, 0,0));
    tbl.push_back(mk(0,1,12, 0,0,0,11,0));
    tbl.push_back(mk(0,1,10, 0,0,0,12,0));
    tbl.push_back(mk(0,1,11, 0,0,0,12,0));
    tbl.push_back(mk(0,0,0,  0,0,0,12,0));
    tbl.push_back(mk(0,0,0,  0,0,0,12,0));
    tbl.push_back(mk(0,0,0,  0,0,0,12,0));

    foreach (tbl[i]) begin
      if (tbl[i].do_rst) begin
        do_reset();
        chk($sformatf("v%0d cfg_err", i), int'(ifc.config_err), 0);
      end else begin
        tick(tbl[i].v, tbl[i].s, 1'b0);
      end
      chk($sformatf("v%0d alarm", i),     int'(ifc.alarm),       int'(tbl[i].ea));
      chk($sformatf("v%0d alarm_set", i), int'(ifc.alarm_set),   int'(tbl[i].es));
      chk($sformatf("v%0d alarm_clr", i), int'(ifc.alarm_clr),   int'(tbl[i].ec));
      chk($sformatf("v%0d peak", i),      int'(ifc.peak),        tbl[i].ep);
      chk($sformatf("v%0d evt", i),       int'(ifc.event_count), tbl[i].ee);
    end

    // inverted thresholds freeze the alarm but not the peak
    do_reset();
    ifc.lo_thr = 4'd12;
    #1;
    chk("cfg_err set", int'(ifc.config_err), 1);
    for (int i = 0; i < 3; i++) tick(1, 15, 0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      chk("cfg frozen alarm", int'(ifc.alarm), 0);
      chk("cfg frozen set", int'(ifc.alarm_set), 0);
    end
    chk("cfg peak", int'(ifc.peak), 15);
    ifc.lo_thr = 4'd5;

    // peak clear aligned with a valid stage-1 sample, then with none
    do_reset();
    tick(1, 13, 0); tick(0, 0, 0); tick(0, 0, 0);
    chk("peak pre-clr", int'(ifc.peak), 13);
    tick(1, 6, 0);
    tick(0, 0, 1);
    chk("peak clr+valid", int'(ifc.peak), 6);
    tick(0, 0, 1);
    chk("peak clr alone", int'(ifc.peak), 0);

    // asynchronous reset in the middle of an arming run
    do_reset();
    tick(1, 11, 0); tick(1, 12, 0);
    rst = 1;
    #1;
    chk("async rst peak", int'(ifc.peak), 0);
    chk("async rst alarm", int'(ifc.alarm), 0);
    chk("async rst evt", int'(ifc.event_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    tick(1, 13, 0);
    check_model("post-rst");
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      check_model("post-rst");
      chk("post-rst no alarm", int'(ifc.alarm), 0);
    end

    // event counter saturation
    do_reset();
    for (int k = 0; k < 260; k++) begin
      for (int j = 0; j < 3; j++) begin tick(1, 12, 0); check_model("sat"); end
      for (int j = 0; j < 3; j++) begin tick(1, 2, 0);  check_model("sat"); end
    end
    for (int j = 0; j < 4; j++) tick(0, 0, 0);
    chk("evt saturated", int'(ifc.event_count), 255);

    // randomized traffic against the model, thresholds changing between segments
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      int sel;
      bit hi_bias;
      if (c % 64 == 0) begin
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: begin ifc.hi_thr = 4'd10; ifc.lo_thr = 4'd5;  end
          1: begin ifc.hi_thr = 4'd8;  ifc.lo_thr = 4'd8;  end
          2: begin ifc.hi_thr = 4'd7;  ifc.lo_thr = 4'd3;  end
          default: begin ifc.hi_thr = 4'd5; ifc.lo_thr = 4'd12; end
        endcase
      end
      hi_bias = ((c / 20) % 2) == 0;
      tick(($urandom_range(0, 3) != 0),
           hi_bias ? int'($urandom_range(6, 15)) : int'($urandom_range(0, 9)),
           ($urandom_range(0, 15) == 0));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
